// File: rtl/jtframe_sdram64_pkg.sv
// rtl/jtframe_sdram64_pkg.sv - shared command encodings, arbiter states and helpers
package jtframe_sdram64_pkg;

    // SDRAM command encodings as {/CS, /RAS, /CAS, /WE}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;

    // Both byte lanes masked
    localparam logic [1:0] DQM_OFF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RGNT = 2'd1,
        ST_RFSH = 2'd2
    } arb_state_t;

    // Index of the set bit in a one-hot (or zero) 4-bit vector
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/jtframe_sdram64_pick.sv
// rtl/jtframe_sdram64_pick.sv - combinational 4-way picker starting at a pointer
module jtframe_sdram64_pick (
    input  logic [3:0] i_elig,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_win,
    output logic       o_valid
);

    logic [1:0] w_pos;

    // Scan from the pointer upwards with wrap; first eligible bank wins
    always_comb begin
        o_win   = 4'b0000;
        o_valid = 1'b0;
        w_pos   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_pos = i_ptr + 2'(k);
            if (!o_valid && i_elig[w_pos]) begin
                o_win[w_pos] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram64_arb.sv
// rtl/jtframe_sdram64_arb.sv - SDRAM command-bus arbiter; JTFRAME_SDRAM64_RR_EN selects round-robin
module jtframe_sdram64_arb
    import jtframe_sdram64_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      i_br,
    input  logic [3:0]      i_idle,
    input  logic [15:0]     i_bank_cmd,
    input  logic [4*AW-1:0] i_bank_a,
    input  logic [7:0]      i_bank_dqm,
    output logic [3:0]      o_bg,
    input  logic            i_rfsh_br,
    input  logic            i_rfshing,
    input  logic [3:0]      i_rfsh_cmd,
    input  logic [AW-1:0]   i_rfsh_a,
    output logic            o_rfsh_bg,
    output logic [3:0]      o_sdram_cmd,
    output logic [1:0]      o_sdram_ba,
    output logic [AW-1:0]   o_sdram_a,
    output logic [1:0]      o_sdram_dqm
);

    arb_state_t    r_state, w_next;
    logic [3:0]    r_bg, w_bg_n;
    logic          r_rfsh_bg, w_rfsh_bg_n;
    logic [3:0]    r_cmd, w_cmd_n;
    logic [1:0]    r_ba, w_ba_n;
    logic [AW-1:0] r_a, w_a_n;
    logic [1:0]    r_dqm, w_dqm_n;

    logic [3:0]    w_elig, w_mask, w_win;
    logic          w_valid, w_grant;
    logic [1:0]    w_idx, w_ptr;

    // A bank still holding br in its grant cycle must not win again;
    // while refresh is pending only banks with open rows may proceed
    assign w_elig = i_br & ~r_bg;
    assign w_mask = i_rfsh_br ? (w_elig & ~i_idle) : w_elig;
    assign w_idx  = onehot_to_idx(w_win);

    jtframe_sdram64_pick u_pick (
        .i_elig  (w_mask),
        .i_ptr   (w_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

`ifdef JTFRAME_SDRAM64_RR_EN
    logic [1:0] r_ptr;

    // Round-robin pointer moves just past the bank that was granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_ptr <= 2'd0;
        else if (w_grant) r_ptr <= w_idx + 2'd1;
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 2'd0;
`endif

    // Next state, grant decision and next pin values
    always_comb begin
        w_next      = r_state;
        w_bg_n      = 4'b0000;
        w_rfsh_bg_n = 1'b0;
        w_cmd_n     = CMD_NOP;
        w_ba_n      = r_ba;
        w_a_n       = r_a;
        w_dqm_n     = DQM_OFF;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rfsh_br && (&i_idle)) begin
                    w_rfsh_bg_n = 1'b1;
                    w_next      = ST_RGNT;
                end else if (w_valid) begin
                    w_grant = 1'b1;
                    w_bg_n  = w_win;
                    w_cmd_n = i_bank_cmd[{w_idx, 2'b00} +: 4];
                    w_ba_n  = w_idx;
                    w_a_n   = i_bank_a[w_idx*AW +: AW];
                    w_dqm_n = i_bank_dqm[{w_idx, 1'b0} +: 2];
                end
            end
            ST_RGNT: begin
                w_cmd_n = i_rfsh_cmd;
                w_a_n   = i_rfsh_a;
                w_next  = ST_RFSH;
            end
            ST_RFSH: begin
                if (i_rfshing) begin
                    w_cmd_n = i_rfsh_cmd;
                    w_a_n   = i_rfsh_a;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State and registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bg      <= 4'b0000;
            r_rfsh_bg <= 1'b0;
            r_cmd     <= CMD_NOP;
            r_ba      <= 2'd0;
            r_a       <= '0;
            r_dqm     <= DQM_OFF;
        end else begin
            r_state   <= w_next;
            r_bg      <= w_bg_n;
            r_rfsh_bg <= w_rfsh_bg_n;
            r_cmd     <= w_cmd_n;
            r_ba      <= w_ba_n;
            r_a       <= w_a_n;
            r_dqm     <= w_dqm_n;
        end
    end

    assign o_bg        = r_bg;
    assign o_rfsh_bg   = r_rfsh_bg;
    assign o_sdram_cmd = r_cmd;
    assign o_sdram_ba  = r_ba;
    assign o_sdram_a   = r_a;
    assign o_sdram_dqm = r_dqm;

endmodule

// File: doc/jtframe_sdram64_arb.md
# jtframe_sdram64_arb

Command-bus arbiter for the 64-bit SDRAM controller. It sits directly downstream of the refresh requester and the four per-bank controllers. It grants one command slot per cycle and multiplexes the winner's command, bank, address and DQM onto the registered SDRAM pins. While a refresh is in progress it locks the bus to the refresh requester.

## Interface
- AW, 13, SDRAM address width.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br  in  4  per-bank command request, one bit per bank controller.
- idle  in  4  bank controller has no open row and no burst in flight.
- bank_cmd  in  16  {cmd3,cmd2,cmd1,cmd0}, 4-bit /CS /RAS /CAS /WE per bank; valid while its br is high.
- bank_a  in  4*AW  per-bank address, packed like bank_cmd.
- bank_dqm  in  8  per-bank 2-bit DQM.
- bg  out  4  one-cycle bank grant pulse.
- rfsh_br  in  1  refresh bus request.
- rfshing  in  1  refresh sequence active.
- rfsh_cmd  in  4  refresh requester command.
- rfsh_a  in  AW  refresh address (A10 set for precharge-all).
- rfsh_bg  out  1  one-cycle refresh grant pulse.
- sdram_cmd  out  4  registered command to pins.
- sdram_ba  out  2  registered bank address.
- sdram_a  out  AW  registered address.
- sdram_dqm  out  2  registered DQM.

## Operation
- States: IDLE, RGNT, RFSH.
- Reset values: bg=0, rfsh_bg=0, sdram_cmd=NOP (4'b0111), sdram_ba=0, sdram_a=0, sdram_dqm=2'b11, state=IDLE, priority pointer=0.
- Eligible bank i: br[i] & ~bg[i]. The mask stops re-granting a bank whose br has not dropped yet.
- IDLE, rfsh_br=1, &idle=1, no bank eligible -> rfsh_bg=1, go to RGNT; pins get NOP.
- IDLE, rfsh_br=1, banks not all idle -> drain mode. Only eligible banks with idle[i]=0 may be granted. Idle banks are blocked, so no new row opens before refresh.
- IDLE otherwise -> pick one eligible bank i and, at the same edge, set bg[i]=1, sdram_cmd=bank_cmd[i], sdram_ba=i, sdram_a=bank_a[i], sdram_dqm=bank_dqm[i].
- IDLE, nothing granted -> sdram_cmd=NOP, DQM=2'b11, ba/a hold.
- RGNT: rfsh_bg=0, forward rfsh_cmd/rfsh_a, go to RFSH.
- RFSH: forward rfsh_cmd/rfsh_a every cycle, grant nothing. Go to IDLE the cycle after rfshing is sampled low; that cycle outputs NOP.
- Bank requests arriving during RGNT/RFSH wait. They keep br high.
- Only one grant of any kind per cycle. bg is one-hot or zero, and never coincides with rfsh_bg.

## Timing
- Grant latency: br high in cycle N -> bg and command on the pins in cycle N+1 (one register stage).
- The requester must drop br in the cycle after it sees bg. If br is still high in the bg cycle, it is ignored.
- Refresh: rfsh_br in N -> rfsh_bg in N+1 -> RFSH from N+2. rfsh_cmd reaches the pins one cycle after the requester drives it.
- Minimum refresh lockout: 3 cycles plus the rfshing high time.
- Asynchronous reset mid-refresh or mid-grant: all outputs return to reset values immediately. No grant is replayed.

## Configuration
- JTFRAME_SDRAM64_RR_EN defined: round-robin. The pointer moves to (granted+1) mod 4 after each bank grant, and the search starts at the pointer.
- JTFRAME_SDRAM64_RR_EN undefined: fixed priority, bank 0 highest, bank 3 lowest. The pointer register is removed.
- Refresh priority and drain rules are the same in both builds.

## Structure
- Shared package jtframe_sdram64_pkg: CMD_* 4-bit encodings (NOP, REFRESH, PRECHARGE, ACTIVE, READ, WRITE), the state enum and DQM_OFF.
- One sub-module, jtframe_sdram64_pick: combinational 4-way picker. Inputs: eligible mask and pointer. Outputs: one-hot winner and valid.

## Test plan
- Single bank: br[2]=1 with ACTIVE, a=13'h123 -> next cycle bg=4'b0100, sdram_cmd=0011, ba=2, a=13'h123. Following cycle NOP, no second grant.
- Contention, RR build: br=4'b1111 held -> bg sequence 0001, 0010, 0100, 1000, 0001. Fixed build -> bg=0001 every cycle br[0] is re-asserted.
- Refresh with all banks idle: rfsh_br=1 -> rfsh_bg pulse one cycle later. rfsh_cmd PRECHARGE then REFRESH forwarded with a=13'h400. bg stays 0 until one cycle after rfshing falls.
- Drain: idle=4'b1110, rfsh_br=1, br=4'b0011 -> bank 0 granted, bank 1 blocked. After idle=4'b1111 and br=0, refresh is granted. Bank 1 is served after the refresh.
- Reset: assert rst_n=0 during RFSH -> sdram_cmd=0111, dqm=2'b11, bg=0, rfsh_bg=0 at once. After release, a bank request is granted normally.
- Simultaneous: rfsh_br and br[3] rise together with all idle -> refresh granted, bg[3] follows after refresh completes.
